// File: rtl/fixed_point_pkg.sv
// Shared constants and FSM encoding for the fixed-point converters.
// Word layout: sign | integer magnitude | fraction (sign-magnitude).
package fixed_point_pkg;

   localparam int INT_BITS  = 15;
   localparam int FRAC_BITS = 16;
   localparam int DEN_WIDTH = 32;

   localparam int WORD_W   = 1 + INT_BITS + FRAC_BITS;
   localparam int SIGN_BIT = WORD_W - 1;
   localparam int INT_LSB  = FRAC_BITS;
   localparam int INT_MSB  = FRAC_BITS + INT_BITS - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_ROUND,
      ST_DONE
   } state_t;

endpackage

// File: rtl/integer_to_fixed_point_if.sv
// Request/response bundle of the integer-to-fixed-point converter.
// master drives requests and consumes results; slave is the converter.
interface integer_to_fixed_point_if #(
   parameter int INT_BITS  = fixed_point_pkg::INT_BITS,
   parameter int FRAC_BITS = fixed_point_pkg::FRAC_BITS,
   parameter int DEN_WIDTH = fixed_point_pkg::DEN_WIDTH
);

   logic                          in_valid;
   logic                          in_ready;
   logic                          in_sign;
   logic [INT_BITS-1:0]           in_int;
   logic [DEN_WIDTH-1:0]          in_num;
   logic [DEN_WIDTH-1:0]          in_den;
   logic                          out_valid;
   logic                          out_ready;
   logic [INT_BITS+FRAC_BITS:0]   out_data;
   logic                          out_error;

   modport master (
      output in_valid, in_sign, in_int, in_num, in_den, out_ready,
      input  in_ready, out_valid, out_data, out_error
   );

   modport slave (
      input  in_valid, in_sign, in_int, in_num, in_den, out_ready,
      output in_ready, out_valid, out_data, out_error
   );

endinterface

// File: rtl/fp_restoring_div_step.sv
// One restoring-division iteration: shift, compare, conditional subtract.
// Remainder is always below den, so the shifted value never loses bits.
module fp_restoring_div_step #(
   parameter int DEN_WIDTH = 32
) (
   input  logic [DEN_WIDTH-1:0] rem,
   input  logic [DEN_WIDTH-1:0] den,
   output logic [DEN_WIDTH-1:0] rem_next,
   output logic                 q_bit
);

   logic [DEN_WIDTH:0] rem2;
   logic [DEN_WIDTH:0] diff;

   // compare the doubled remainder against den and restore on underflow
   always_comb begin
      rem2     = {rem, 1'b0};
      diff     = rem2 - {1'b0, den};
      q_bit    = (rem2 >= {1'b0, den});
      rem_next = q_bit ? diff[DEN_WIDTH-1:0] : rem2[DEN_WIDTH-1:0];
   end

endmodule

// File: rtl/integer_to_fixed_point.sv
// Builds a sign-magnitude fixed-point word from sign, integer and num/den.
// Fraction bits come from restoring division plus one round bit.
module integer_to_fixed_point
   import fixed_point_pkg::state_t;
   import fixed_point_pkg::ST_IDLE;
   import fixed_point_pkg::ST_DIV;
   import fixed_point_pkg::ST_ROUND;
   import fixed_point_pkg::ST_DONE;
#(
   parameter int INT_BITS  = fixed_point_pkg::INT_BITS,
   parameter int FRAC_BITS = fixed_point_pkg::FRAC_BITS,
   parameter int DEN_WIDTH = fixed_point_pkg::DEN_WIDTH
) (
   input logic                      clock,
   input logic                      reset,
   integer_to_fixed_point_if.slave  bus
);

   localparam int WORD_W = 1 + INT_BITS + FRAC_BITS;
   localparam int CNT_W  = $clog2(FRAC_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(FRAC_BITS);

   state_t                 state;
   logic [DEN_WIDTH-1:0]   rem_q;
   logic [DEN_WIDTH-1:0]   den_q;
   logic [FRAC_BITS:0]     quot_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sign_q;
   logic [INT_BITS-1:0]    int_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic [WORD_W-1:0]      out_data_q;
   logic                   out_error_q;

   logic [DEN_WIDTH-1:0]   rem_next;
   logic                   q_bit;

   logic [FRAC_BITS:0]     frac_sum;
   logic [INT_BITS:0]      int_sum;
   logic                   sat;
   logic [WORD_W-2:0]      mag;
   logic                   rnd_sign;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_error = out_error_q;

   fp_restoring_div_step #(
      .DEN_WIDTH (DEN_WIDTH)
   ) u_step (
      .rem      (rem_q),
      .den      (den_q),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // round half up on the magnitude, carry into integer, saturate on wrap
   always_comb begin
      frac_sum = {1'b0, quot_q[FRAC_BITS:1]}
               + {{FRAC_BITS{1'b0}}, quot_q[0]};
      int_sum  = {1'b0, int_q}
               + {{INT_BITS{1'b0}}, frac_sum[FRAC_BITS]};
      sat      = int_sum[INT_BITS];
      mag      = sat ? '1
               : {int_sum[INT_BITS-1:0], frac_sum[FRAC_BITS-1:0]};
      rnd_sign = sign_q && (mag != '0);
   end

   // request/divide/round/present sequencer with registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         rem_q       <= '0;
         den_q       <= '0;
         quot_q      <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         int_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_error_q <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  sign_q     <= bus.in_sign;
                  int_q      <= bus.in_int;
                  den_q      <= bus.in_den;
                  rem_q      <= bus.in_num;
                  quot_q     <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  if (bus.in_den == '0 || bus.in_num >= bus.in_den) begin
                     out_data_q  <= '0;
                     out_error_q <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     state <= ST_DIV;
                  end
               end
            end
            ST_DIV: begin
               rem_q  <= rem_next;
               quot_q <= {quot_q[FRAC_BITS-1:0], q_bit};
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST_IT)
                  state <= ST_ROUND;
            end
            ST_ROUND: begin
               out_data_q  <= {rnd_sign, mag};
               out_error_q <= sat;
               state       <= ST_DONE;
            end
            ST_DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
